piezo_alert_sequencer: RTL
==========================

// Module: piezo_alert_sequencer
// PURPOSE
//  Parametrised alert sequencer driving the piezo. It merges the countdown-timer beep with NUM_CH
//  prioritised event-warning requests into one gated output. Timer beeps use a 3-tier period:
//  long, short (<1 min) and urgent (<URGENT_SEC). Timeout (00:00) gives a steady alarm.
//  Sits between main_fsm/game_timer/event blocks and the piezo pin.
// PARAMETERS
//  CLK_FREQ_HZ       50_000_000  system clock; ticks = CLK_FREQ_HZ/1000*ms
//  NUM_CH            4           event request channels (1..8)
//  ON_MS             500         timer beep on-time
//  PERIOD_LONG_MS    5000        gap between timer beeps, >=60 s remaining
//  PERIOD_SHORT_MS   2000        gap, <60 s remaining
//  PERIOD_URGENT_MS  500         gap, <URGENT_SEC remaining
//  URGENT_SEC        10          urgent threshold, seconds (1..59)
//  CH_ON_MS          100         event-pattern on-time
//  CH_OFF_MS         100         event-pattern off-time
//  TONE_HZ           2000        tone frequency (used only with PIEZO_TONE_EN)
// PORTS
//  clk          in   1                  system clock
//  sys_rst      in   1                  synchronous active-high reset
//  game_enable  in   1                  sequencer runs only while high
//  time_bcd     in   16                 remaining time, BCD MM:SS
//  ch_req       in   NUM_CH             level requests; bit 0 = highest priority
//  piezo_out    out  1                  piezo drive
//  beep_pulse   out  1                  1-cycle strobe on entry to BEEP or CH_ON
//  active_src   out  $clog2(NUM_CH+1)   0 = timer/idle, k = channel k-1
// BEHAVIOUR
//  - Reset: one clock and one reset. The reset is synchronous and active-high. On reset the state
//    is IDLE, cnt=0, piezo_out=0, beep_pulse=0 and active_src=0. sys_rst wins over all other inputs.
//  - States: IDLE, GAP, BEEP, CH_ON, CH_OFF, ALARM. The gate is high in BEEP, CH_ON and ALARM.
//    The gate is decoded from the state register only (no extra cycle of latency).
//  - Any state with game_enable=0: go to IDLE next cycle, cnt=0, active_src=0.
//  - IDLE with game_enable=1: go to GAP, cnt=0.
//  - Tier is evaluated combinationally every cycle:
//    - urgent if MM==00 and SS < URGENT_SEC;
//    - short if MM==00;
//    - long otherwise.
//    - Any BCD digit >9 forces long.
//  - GAP: cnt++.
//    - When cnt >= period_ticks-1: go to BEEP, cnt=0, beep_pulse=1.
//    - ">=" makes a tier drop mid-gap fire immediately.
//  - BEEP: when cnt == ON_ticks-1, go to GAP with cnt=0.
//  - GAP/BEEP with |ch_req: go to CH_ON next cycle. cnt=0, active_src = lowest set index+1,
//    beep_pulse=1. This preempts a running beep.
//  - CH_ON: when cnt == CH_ON_ticks-1, go to CH_OFF. A dropped request does not cut the burst short.
//  - CH_OFF: when cnt == CH_OFF_ticks-1:
//    - if |ch_req: go to CH_ON, re-latch the priority, pulse;
//    - else: go to GAP, cnt=0, active_src=0.
//  - Simultaneous events, highest priority first:
//    !game_enable > timeout > ch_req > period expiry > on-time expiry.
//  - Timeout: time_bcd==16'h0000 with game_enable in any active state goes to ALARM.
//    ALARM holds the gate high and active_src=0 until game_enable falls.
//  - Counter: 32-bit, never wraps; it always resets on a state change.
// CONFIGURATION
//  - Macro PIEZO_TONE_EN defined: piezo_out = gate & tone.
//    - tone is a square wave of CLK_FREQ_HZ/(2*TONE_HZ) ticks per half-period.
//    - The divider is held at 0 while the gate is low, so each burst starts in the high phase.
//  - Macro undefined: piezo_out = gate (level drive for an active buzzer). TONE_HZ is unused.
// STRUCTURE
//  - Shared package piezo_alert_pkg.vh:
//    - state encoding localparams (3 bits);
//    - function ms_to_ticks(clk_hz, ms);
//    - function bcd_valid(digit).
//  - Sub-module piezo_tone_gen (clk, sys_rst, gate -> tone), instantiated only under PIEZO_TONE_EN.
//  - Priority encoder stays a local function.
// TESTING (CLK_FREQ_HZ=1000, ON_MS=5, LONG=50, SHORT=20, URGENT=10, CH_ON=3, CH_OFF=2, NUM_CH=4)
//  1. Long tier:
//     - stimulus: reset, enable=1, time=16'h0130;
//     - required: first beep_pulse at cycle 51 after enable;
//     - required: gate high for 5 cycles, then period 55 cycles.
//  2. Tier drop:
//     - stimulus: time moves 16'h0100 -> 16'h0059 while GAP cnt=30;
//     - required: BEEP next cycle.
//     - stimulus: at 16'h0009;
//     - required: gap is 10 cycles.
//  3. Preemption:
//     - stimulus: ch_req=4'b1010 raised mid-BEEP;
//     - required: CH_ON next cycle, active_src=2, pattern 3 on / 2 off.
//     - stimulus: bit1 drops;
//     - required: active_src=4 at next CH_ON.
//     - stimulus: req=0;
//     - required: GAP, active_src=0.
//  4. Timeout:
//     - stimulus: time=16'h0000 during CH_ON;
//     - required: ALARM, gate steady 1.
//     - stimulus: enable=0;
//     - required: IDLE and piezo_out=0 after 1 cycle.
//  5. Reset mid-BEEP:
//     - stimulus: sys_rst for 1 cycle;
//     - required: all outputs 0, state IDLE.
//     - stimulus: invalid time 16'h00AA;
//     - required: long period used.
//  6. With PIEZO_TONE_EN, TONE_HZ=100:
//     - required: piezo_out toggles every 5 cycles inside BEEP;
//     - required: output is high on the first cycle of the burst;
//     - required: output is 0 in GAP.

Source files
------------

// File: rtl/piezo_alert_pkg.sv
// Shared types and helpers for the piezo alert sequencer: state encoding,
// beep-period tiers, millisecond-to-tick conversion and BCD helpers.
package piezo_alert_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GAP    = 3'd1;
  localparam logic [2:0] ST_BEEP   = 3'd2;
  localparam logic [2:0] ST_CH_ON  = 3'd3;
  localparam logic [2:0] ST_CH_OFF = 3'd4;
  localparam logic [2:0] ST_ALARM  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    GAP    = ST_GAP,
    BEEP   = ST_BEEP,
    CH_ON  = ST_CH_ON,
    CH_OFF = ST_CH_OFF,
    ALARM  = ST_ALARM
  } state_e;

  typedef enum logic [1:0] {
    TIER_LONG,
    TIER_SHORT,
    TIER_URGENT
  } tier_e;

  // Never returns 0, so every "ticks-1" terminal count stays meaningful.
  function automatic logic [31:0] ms_to_ticks(input longint unsigned clk_hz,
                                               input longint unsigned ms);
    longint unsigned t;
    t = clk_hz / 1000 * ms;
    if (t == 0) t = 1;
    if (t > 64'h0000_0000_FFFF_FFFF) t = 64'h0000_0000_FFFF_FFFF;
    return t[31:0];
  endfunction

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input logic [7:0] bcd);
    return ({3'd0, bcd[7:4]} * 7'd10) + {3'd0, bcd[3:0]};
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave tone source for a passive piezo. The divider is parked while the
// gate is low so every burst begins in the high phase.
module piezo_tone_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TONE_HZ     = 2000
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic gate,
  output logic tone
);

  localparam int unsigned HALF_RAW   = CLK_FREQ_HZ / (2 * TONE_HZ);
  localparam logic [31:0] HALF_TICKS = (HALF_RAW == 0) ? 32'd1 : 32'(HALF_RAW);

  logic [31:0] div_q;
  logic        phase_q;

  always_ff @(posedge clk) begin
    if (sys_rst || !gate) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else if (div_q == HALF_TICKS - 32'd1) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      div_q <= div_q + 32'd1;
    end
  end

  assign tone = ~phase_q;

endmodule

// File: rtl/piezo_alert_sequencer.sv
// Merges the countdown beep (3-tier period) with prioritised event requests
// into one piezo gate. Define PIEZO_TONE_EN to modulate the gate with a tone.
module piezo_alert_sequencer
  import piezo_alert_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned ON_MS            = 500,
  parameter int unsigned PERIOD_LONG_MS   = 5000,
  parameter int unsigned PERIOD_SHORT_MS  = 2000,
  parameter int unsigned PERIOD_URGENT_MS = 500,
  parameter int unsigned URGENT_SEC       = 10,
  parameter int unsigned CH_ON_MS         = 100,
  parameter int unsigned CH_OFF_MS        = 100,
  parameter int unsigned TONE_HZ          = 2000
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         game_enable,
  input  logic [15:0]                  time_bcd,
  input  logic [NUM_CH-1:0]            ch_req,
  output logic                         piezo_out,
  output logic                         beep_pulse,
  output logic [$clog2(NUM_CH+1)-1:0]  active_src
);

  localparam int unsigned SRC_W = $clog2(NUM_CH + 1);

  localparam logic [31:0] ON_TICKS      = ms_to_ticks(CLK_FREQ_HZ, ON_MS);
  localparam logic [31:0] LONG_TICKS    = ms_to_ticks(CLK_FREQ_HZ, PERIOD_LONG_MS);
  localparam logic [31:0] SHORT_TICKS   = ms_to_ticks(CLK_FREQ_HZ, PERIOD_SHORT_MS);
  localparam logic [31:0] URGENT_TICKS  = ms_to_ticks(CLK_FREQ_HZ, PERIOD_URGENT_MS);
  localparam logic [31:0] CH_ON_TICKS   = ms_to_ticks(CLK_FREQ_HZ, CH_ON_MS);
  localparam logic [31:0] CH_OFF_TICKS  = ms_to_ticks(CLK_FREQ_HZ, CH_OFF_MS);

  // Lowest set bit wins; result is index+1 so that 0 can mean "timer".
  function automatic logic [SRC_W-1:0] first_req(input logic [NUM_CH-1:0] req);
    logic [SRC_W-1:0] src;
    src = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) src = SRC_W'(i + 1);
    end
    return src;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, cnt_inc;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              pulse_q, pulse_d;

  logic              time_valid, mm_zero, timeout, any_req;
  logic [6:0]        ss_bin;
  tier_e             tier;
  logic [31:0]       period_ticks;
  logic              gate;

  assign time_valid = bcd_valid(time_bcd[15:12]) && bcd_valid(time_bcd[11:8]) &&
                      bcd_valid(time_bcd[7:4])   && bcd_valid(time_bcd[3:0]);
  assign mm_zero    = (time_bcd[15:8] == 8'h00);
  assign ss_bin     = bcd2_to_bin(time_bcd[7:0]);
  assign timeout    = (time_bcd == 16'h0000);
  assign any_req    = |ch_req;

  always_comb begin
    tier = TIER_LONG;
    if (time_valid && mm_zero) begin
      tier = ({25'd0, ss_bin} < URGENT_SEC) ? TIER_URGENT : TIER_SHORT;
    end
  end

  always_comb begin
    case (tier)
      TIER_URGENT: period_ticks = URGENT_TICKS;
      TIER_SHORT:  period_ticks = SHORT_TICKS;
      default:     period_ticks = LONG_TICKS;
    endcase
  end

  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_inc;
    src_d   = src_q;
    pulse_d = 1'b0;

    if (!game_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      src_d   = '0;
    end else if (state_q != IDLE && timeout) begin
      state_d = ALARM;
      src_d   = '0;
      if (state_q != ALARM) cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          cnt_d   = '0;
        end
        GAP, BEEP: begin
          if (any_req) begin
            state_d = CH_ON;
            cnt_d   = '0;
            src_d   = first_req(ch_req);
            pulse_d = 1'b1;
          end else if (state_q == GAP && cnt_q >= period_ticks - 32'd1) begin
            // ">=" lets a tier drop mid-gap fire at once.
            state_d = BEEP;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else if (state_q == BEEP && cnt_q == ON_TICKS - 32'd1) begin
            state_d = GAP;
            cnt_d   = '0;
          end
        end
        CH_ON: begin
          if (cnt_q == CH_ON_TICKS - 32'd1) begin
            state_d = CH_OFF;
            cnt_d   = '0;
          end
        end
        CH_OFF: begin
          if (cnt_q == CH_OFF_TICKS - 32'd1) begin
            cnt_d = '0;
            if (any_req) begin
              state_d = CH_ON;
              src_d   = first_req(ch_req);
              pulse_d = 1'b1;
            end else begin
              state_d = GAP;
              src_d   = '0;
            end
          end
        end
        ALARM:   state_d = ALARM;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          src_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      pulse_q <= pulse_d;
    end
  end

  assign gate       = (state_q == BEEP) || (state_q == CH_ON) || (state_q == ALARM);
  assign beep_pulse = pulse_q;
  assign active_src = src_q;

`ifdef PIEZO_TONE_EN
  logic tone;

  piezo_tone_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TONE_HZ     (TONE_HZ)
  ) u_tone (
    .clk     (clk),
    .sys_rst (sys_rst),
    .gate    (gate),
    .tone    (tone)
  );

  assign piezo_out = gate & tone;
`else
  assign piezo_out = gate;
`endif

endmodule
